mem_access_stage: RTL and testbench

Memory-stage access unit that sits between the EX/MEM pipeline register and the MEM/WB write-back register. It turns load/store requests into a req/ack transaction on the data-memory bus and stalls the pipeline while the access is outstanding. It presents ReadData, ALUOut, RegW, MemToReg and WriteReg in the exact form the write-back register samples. Non-memory instructions pass through with zero added latency.

---
 rtl/mem_access_stage.sv | 157 +++++++++++++++
 tb/tb_mem_access_stage.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// mem_access_stage: memory-stage access unit between EX/MEM and MEM/WB.
// Turns load/store requests into a registered req/ack bus transaction and
// stalls the pipeline while the access is outstanding. Non-memory
// instructions pass straight through with no added latency.
//
// Ports:
//   clk, reset            clock; synchronous active-low reset
//   RegWM..WriteRegM      EX/MEM pipeline register fields
//   RegWOut..WriteRegOut  fields presented to the MEM/WB register
//   StallM                freeze upstream stages while an access is pending
//   mem_req/we/addr/wdata registered data-memory bus request
//   mem_rdata, mem_ack    bus read data and single-cycle completion pulse
//   misalign_err          combinational flag for a misaligned access
//   bus_err               one-cycle pulse in DONE after a timeout abort
//
// Optional feature: define MEM_TIMEOUT_EN to abort a WAIT that lasts
// TIMEOUT_CYCLES cycles without ack. Without it bus_err is tied to 0.
module mem_access_stage #(
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned REG_W          = 5,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              RegWM,
  input  logic              MemToRegM,
  input  logic              MemReadM,
  input  logic              MemWriteM,
  input  logic [DATA_W-1:0] ALUOutM,
  input  logic [DATA_W-1:0] WriteDataM,
  input  logic [REG_W-1:0]  WriteRegM,
  output logic              RegWOut,
  output logic              MemToRegOut,
  output logic [DATA_W-1:0] ReadDataOut,
  output logic [DATA_W-1:0] ALUOutOut,
  output logic [REG_W-1:0]  WriteRegOut,
  output logic              StallM,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              misalign_err,
  output logic              bus_err
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  state_e            state_q, state_d, state_cur;
  logic              mem_op, misaligned, start, timeout_hit, abort;
  logic [DATA_W-1:0] rdata_q;
  logic [CntW-1:0]   to_cnt_q;

  assign mem_op     = MemReadM | MemWriteM;
  assign misaligned = |ALUOutM[1:0];

  // Combinational outputs behave as in IDLE while reset is held low.
  assign state_cur = reset ? state_q : StIdle;

`ifdef MEM_TIMEOUT_EN
  assign timeout_hit = (to_cnt_q == CntW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d      = state_cur;
    RegWOut      = 1'b0;
    MemToRegOut  = 1'b0;
    ReadDataOut  = '0;
    ALUOutOut    = ALUOutM;
    WriteRegOut  = WriteRegM;
    StallM       = 1'b0;
    misalign_err = 1'b0;
    start        = 1'b0;
    abort        = 1'b0;
    unique case (state_cur)
      StIdle: begin
        if (!mem_op) begin
          RegWOut     = RegWM;
          MemToRegOut = MemToRegM;
        end else if (misaligned) begin
          misalign_err = 1'b1;
        end else begin
          StallM  = 1'b1;
          start   = 1'b1;
          state_d = StWait;
        end
      end
      StWait: begin
        StallM = 1'b1;
        if (mem_ack) begin
          state_d = StDone;
        end else if (timeout_hit) begin
          abort   = 1'b1;
          state_d = StDone;
        end
      end
      StDone: begin
        // After an abort rdata_q is still zero and the write is suppressed.
        RegWOut     = RegWM & ~bus_err;
        MemToRegOut = MemToRegM;
        ReadDataOut = rdata_q;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= StIdle;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rdata_q   <= '0;
      to_cnt_q  <= '0;
    end else begin
      state_q <= state_d;
      if (start) begin
        mem_req   <= 1'b1;
        mem_we    <= MemWriteM;
        mem_addr  <= ALUOutM;
        mem_wdata <= WriteDataM;
        rdata_q   <= '0;
        to_cnt_q  <= '0;
      end else if (state_q == StWait) begin
        if (mem_ack || abort) begin
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
          // Stores (including read+write) leave the captured data at zero.
          if (mem_ack && !mem_we) rdata_q <= mem_rdata;
        end else if (to_cnt_q != CntW'(TIMEOUT_CYCLES)) begin
          to_cnt_q <= to_cnt_q + 1'b1;
        end
      end
    end
  end

`ifdef MEM_TIMEOUT_EN
  logic bus_err_q;

  always_ff @(posedge clk) begin
    if (!reset) bus_err_q <= 1'b0;
    else        bus_err_q <= abort;
  end

  assign bus_err = bus_err_q;
`else
  assign bus_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;
  localparam int DW = 32;
  localparam int RW = 5;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          RegWM, MemToRegM, MemReadM, MemWriteM;
  logic [DW-1:0] ALUOutM, WriteDataM;
  logic [RW-1:0] WriteRegM;
  logic          RegWOut, MemToRegOut, StallM;
  logic [DW-1:0] ReadDataOut, ALUOutOut;
  logic [RW-1:0] WriteRegOut;
  logic          mem_req, mem_we, mem_ack, misalign_err, bus_err;
  logic [DW-1:0] mem_addr, mem_wdata, mem_rdata;

  int tests = 0;
  int fails = 0;

  mem_access_stage #(
    .DATA_W(DW),
    .REG_W(RW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .RegWM(RegWM),
    .MemToRegM(MemToRegM),
    .MemReadM(MemReadM),
    .MemWriteM(MemWriteM),
    .ALUOutM(ALUOutM),
    .WriteDataM(WriteDataM),
    .WriteRegM(WriteRegM),
    .RegWOut(RegWOut),
    .MemToRegOut(MemToRegOut),
    .ReadDataOut(ReadDataOut),
    .ALUOutOut(ALUOutOut),
    .WriteRegOut(WriteRegOut),
    .StallM(StallM),
    .mem_req(mem_req),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ack(mem_ack),
    .misalign_err(misalign_err),
    .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  // Flags compared as one vector: {StallM, RegWOut, MemToRegOut, mem_req, mem_we,
  // misalign_err, bus_err}.
  function automatic logic [6:0] flags();
    return {StallM, RegWOut, MemToRegOut, mem_req, mem_we, misalign_err, bus_err};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic rw, input logic mtr, input logic rd, input logic wr,
                        input logic [DW-1:0] alu, input logic [DW-1:0] wd,
                        input logic [RW-1:0] wreg);
    RegWM = rw; MemToRegM = mtr; MemReadM = rd; MemWriteM = wr;
    ALUOutM = alu; WriteDataM = wd; WriteRegM = wreg;
  endtask

  // Non-memory op: pass-through in the same cycle, optional stray ack ignored.
  task automatic run_nonmem(input logic rw, input logic mtr, input logic [DW-1:0] alu,
                            input logic [RW-1:0] wreg, input logic glitch, input string tag);
    logic [6:0] ef;
    set_in(rw, mtr, 1'b0, 1'b0, alu, $urandom, wreg);
    mem_ack = glitch; mem_rdata = $urandom;
    @(negedge clk);
    ef = {1'b0, rw, mtr, 4'b0000};
    tests++;
    if (flags() !== ef) begin
      fails++; $display("FAIL %s flags: got %b want %b", tag, flags(), ef);
    end
    tests++;
    if ({ALUOutOut, WriteRegOut, ReadDataOut} !== {alu, wreg, 32'h0}) begin
      fails++;
      $display("FAIL %s data: got %h/%h/%h want %h/%h/0", tag, ALUOutOut, WriteRegOut,
               ReadDataOut, alu, wreg);
    end
    step();
    mem_ack = 1'b0;
  endtask

  // Memory op model: 1 IDLE stall cycle, n WAIT cycles (ack on the n-th), 1 DONE cycle.
  task automatic run_mem_op(input logic rd, input logic wr, input logic rw, input logic mtr,
                            input logic [DW-1:0] alu, input logic [DW-1:0] wd,
                            input logic [RW-1:0] wreg, input int n,
                            input logic [DW-1:0] rdata, input logic done_ack,
                            input string tag);
    logic [6:0]    ef;
    logic [DW-1:0] exp_rd;
    set_in(rw, mtr, rd, wr, alu, wd, wreg);
    mem_ack = 1'b0; mem_rdata = $urandom;
    if (alu[1:0] != 2'b00) begin
      for (int c = 0; c < 2; c++) begin
        @(negedge clk);
        ef = 7'b0000010;
        tests++;
        if (flags() !== ef) begin
          fails++; $display("FAIL %s misalign c%0d: got %b want %b", tag, c, flags(), ef);
        end
        step();
      end
      return;
    end
    @(negedge clk);
    ef = 7'b1000000;
    tests++;
    if ({flags(), ReadDataOut} !== {ef, 32'h0}) begin
      fails++;
      $display("FAIL %s idle: got %b/%h want %b/0", tag, flags(), ReadDataOut, ef);
    end
    for (int k = 1; k <= n; k++) begin
      step();
      mem_ack = (k == n);
      mem_rdata = (k == n) ? rdata : $urandom;
      @(negedge clk);
      ef = {4'b1001, wr, 2'b00};
      tests++;
      if (flags() !== ef) begin
        fails++; $display("FAIL %s wait%0d: got %b want %b", tag, k, flags(), ef);
      end
      tests++;
      if ({mem_addr, mem_wdata} !== {alu, wd}) begin
        fails++;
        $display("FAIL %s bus%0d: got %h/%h want %h/%h", tag, k, mem_addr, mem_wdata, alu, wd);
      end
    end
    step();
    mem_ack = done_ack; mem_rdata = $urandom;
    @(negedge clk);
    exp_rd = wr ? 32'h0 : rdata;
    ef = {1'b0, rw, mtr, 4'b0000};
    tests++;
    if (flags() !== ef) begin
      fails++; $display("FAIL %s done: got %b want %b", tag, flags(), ef);
    end
    tests++;
    if ({ReadDataOut, ALUOutOut, WriteRegOut} !== {exp_rd, alu, wreg}) begin
      fails++;
      $display("FAIL %s result: got %h/%h/%h want %h/%h/%h", tag, ReadDataOut, ALUOutOut,
               WriteRegOut, exp_rd, alu, wreg);
    end
    step();
    mem_ack = 1'b0;
  endtask

  task automatic test_reset();
    logic [6:0] ef;
    reset = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    set_in(1'b1, 1'b1, 1'b1, 1'b0, 32'h40, 32'h5, 5'd3);
    for (int c = 0; c < 2; c++) begin
      step();
      @(negedge clk);
      ef = 7'b1000000;  // aligned load seen with IDLE rules, but no request
      tests++;
      if ({flags(), mem_addr, mem_wdata, ReadDataOut} !== {ef, 96'h0}) begin
        fails++;
        $display("FAIL reset c%0d: got %b/%h/%h/%h want %b/0/0/0", c, flags(), mem_addr,
                 mem_wdata, ReadDataOut, ef);
      end
    end
    step();
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    reset = 1'b1;
  endtask

  task automatic test_directed();
    run_nonmem(1'b1, 1'b0, 32'h1234, 5'd7, 1'b0, "nonmem");
    run_mem_op(1'b1, 1'b0, 1'b1, 1'b1, 32'h100, 32'h0, 5'd9, 3, 32'hCAFEF00D, 1'b0, "load");
    run_mem_op(1'b0, 1'b1, 1'b0, 1'b0, 32'h204, 32'hA5A5A5A5, 5'd0, 1, 32'h1111, 1'b0, "store");
    run_mem_op(1'b1, 1'b0, 1'b1, 1'b1, 32'h102, 32'h0, 5'd4, 1, 32'h0, 1'b0, "misalign");
    run_mem_op(1'b1, 1'b1, 1'b1, 1'b0, 32'h308, 32'h77, 5'd2, 2, 32'hBEEF, 1'b0, "rdwr");
    run_nonmem(1'b1, 1'b1, 32'hFACE, 5'd31, 1'b1, "ack_idle");
  endtask

  task automatic test_back_to_back();
    run_mem_op(1'b1, 1'b0, 1'b1, 1'b1, 32'h10, 32'h0, 5'd1, 1, 32'h1234ABCD, 1'b1, "b2b_ld");
    run_mem_op(1'b0, 1'b1, 1'b0, 1'b0, 32'h14, 32'h9, 5'd2, 2, 32'h0, 1'b0, "b2b_st");
    run_mem_op(1'b1, 1'b0, 1'b1, 1'b1, 32'h18, 32'h0, 5'd3, 1, 32'h55AA55AA, 1'b0, "b2b_ld2");
  endtask

  task automatic test_reset_mid_wait();
    logic [6:0] ef;
    set_in(1'b1, 1'b1, 1'b1, 1'b0, 32'h300, 32'h0, 5'd5);
    step();
    step();  // second WAIT cycle
    reset = 1'b0;
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 32'h42, 32'h0, 5'd6);
    step();
    reset = 1'b1;
    mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      ef = 7'b0100000;
      tests++;
      if ({flags(), ReadDataOut, mem_addr} !== {ef, 64'h0}) begin
        fails++;
        $display("FAIL rst_wait c%0d: got %b/%h/%h want %b/0/0", c, flags(), ReadDataOut,
                 mem_addr, ef);
      end
      step();
      mem_ack = 1'b0;
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      int            kind;
      int            maxn;
      logic [DW-1:0] alu;
      logic          rd, wr;
      kind = $urandom_range(0, 4);
`ifdef MEM_TIMEOUT_EN
      maxn = TO - 1;
`else
      maxn = 6;
`endif
      alu = $urandom & 32'hFFFF_FFFC;
      rd = kind == 1 || kind == 3;
      wr = kind == 2 || kind == 3;
      if (kind == 4) begin
        alu[1:0] = 2'($urandom_range(1, 3));
        rd = $urandom_range(0, 1) == 1;
        wr = !rd || ($urandom_range(0, 1) == 1);
      end
      if (kind == 0)
        run_nonmem(1'($urandom), 1'($urandom), $urandom, 5'($urandom), 1'($urandom), "rnd_nm");
      else
        run_mem_op(rd, wr, 1'($urandom), 1'($urandom), alu, $urandom, 5'($urandom),
                   $urandom_range(1, maxn), $urandom, 1'($urandom), "rnd_mem");
    end
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic test_timeout();
    logic [6:0] ef;
    set_in(1'b1, 1'b1, 1'b1, 1'b0, 32'h80, 32'h0, 5'd8);
    mem_ack = 1'b0;
    for (int k = 1; k <= TO; k++) begin
      step();
      @(negedge clk);
      ef = 7'b1001000;
      tests++;
      if (flags() !== ef) begin
        fails++; $display("FAIL timeout wait%0d: got %b want %b", k, flags(), ef);
      end
    end
    step();
    @(negedge clk);
    ef = 7'b0010001;
    tests++;
    if ({flags(), ReadDataOut} !== {ef, 32'h0}) begin
      fails++;
      $display("FAIL timeout done: got %b/%h want %b/0", flags(), ReadDataOut, ef);
    end
    step();
    run_nonmem(1'b1, 1'b0, 32'h99, 5'd1, 1'b0, "after_timeout");
  endtask
`else
  task automatic test_long_wait();
    run_mem_op(1'b1, 1'b0, 1'b1, 1'b1, 32'h400, 32'h0, 5'd12, 20, 32'h0BADF00D, 1'b0, "long");
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_mid_wait();
`ifdef MEM_TIMEOUT_EN
    test_timeout();
`else
    test_long_wait();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
